// File: rtl/pix24to8_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : pix24to8_tx_if
// Description : Request, VRAM read and byte-stream signals of pix24to8_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface pix24to8_tx_if;
    logic        start;
    logic [16:0] startaddr;
    logic        vram_rd;
    logic [16:0] vram_addr;
    logic [7:0]  vram_r;
    logic [7:0]  vram_g;
    logic [7:0]  vram_b;
    logic [7:0]  data8b;
    logic        en;
    logic        busy;
    logic        done;

    modport master (
        input  start, startaddr, vram_r, vram_g, vram_b,
        output vram_rd, vram_addr, data8b, en, busy, done
    );

    modport slave (
        output start, startaddr, vram_r, vram_g, vram_b,
        input  vram_rd, vram_addr, data8b, en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pix24to8_tx.sv
`default_nettype none
// ============================================================================
// Module      : pix24to8_tx
// Description : Streams a 7-byte header then NPIX RGB pixels read from VRAM
//               as a contiguous byte burst, followed by an idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module pix24to8_tx #(
    parameter int NPIX       = 480,
    parameter int VRAM_DEPTH = 76800,
    parameter int GAP        = 4
) (
    input  logic          dclk,
    input  logic          rst,
    pix24to8_tx_if.master bus
);
    localparam int              c_CW       = $clog2(3*NPIX + 8);
    localparam int              c_GW       = $clog2(GAP + 1);
    localparam logic [c_CW-1:0] c_HDR_LAST = c_CW'(6);
    localparam logic [c_CW-1:0] c_PIX_LAST = c_CW'(3*NPIX + 6);
    localparam logic [c_CW-1:0] c_RD_LAST  = c_CW'(3*NPIX + 4);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP);
    localparam logic [16:0]     c_ADDR_MAX = 17'(VRAM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PIX  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]        r_ph, w_ph_nxt;
    logic [c_GW-1:0]   r_gcnt, w_gcnt_nxt;
    logic [16:0]       r_sa, w_sa_nxt;
    logic [16:0]       r_paddr, w_paddr_nxt, w_paddr_inc, w_sa_clean;
    logic [23:0]       r_hold, w_rgb;
    logic              r_rd_q;
    logic              r_vram_rd, w_rd_nxt;
    logic [16:0]       r_vram_addr, w_addr_nxt;
    logic [7:0]        r_data, w_data_nxt;
    logic              r_en, w_en_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    // The R byte leaves on the same edge the hold register loads, so it is
    // taken from the read port directly; G and B come from the hold register.
    assign w_rgb       = r_rd_q ? {bus.vram_r, bus.vram_g, bus.vram_b} : r_hold;
    assign w_paddr_inc = (r_paddr == c_ADDR_MAX) ? 17'd0 : r_paddr + 17'd1;
    assign w_sa_clean  = (bus.startaddr > c_ADDR_MAX) ? 17'd0 : bus.startaddr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ph_nxt    = r_ph;
        w_gcnt_nxt  = r_gcnt;
        w_sa_nxt    = r_sa;
        w_paddr_nxt = r_paddr;
        w_rd_nxt    = 1'b0;
        w_addr_nxt  = r_vram_addr;
        w_data_nxt  = 8'd0;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_HDR;
                    w_cnt_nxt   = '0;
                    w_sa_nxt    = w_sa_clean;
                    w_paddr_nxt = w_sa_clean;
                end
            end
            S_HDR: begin
                w_en_nxt  = 1'b1;
                w_cnt_nxt = r_cnt + c_CW'(1);
                case (r_cnt[2:0])
                    3'd0:    w_data_nxt = {7'd0, r_sa[16]};
                    3'd1:    w_data_nxt = r_sa[15:8];
                    3'd2:    w_data_nxt = r_sa[7:0];
                    3'd3:    w_data_nxt = 8'h04;
                    3'd4:    w_data_nxt = 8'h40;
                    default: w_data_nxt = 8'h00;
                endcase
                if (r_cnt[2:0] == 3'd5) begin
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = r_paddr;
                    w_paddr_nxt = w_paddr_inc;
                end
                if (r_cnt == c_HDR_LAST) begin
                    w_state_nxt = S_PIX;
                    w_ph_nxt    = 2'd0;
                end
            end
            S_PIX: begin
                w_en_nxt  = 1'b1;
                w_cnt_nxt = r_cnt + c_CW'(1);
                w_ph_nxt  = (r_ph == 2'd2) ? 2'd0 : r_ph + 2'd1;
                case (r_ph)
                    2'd0:    w_data_nxt = w_rgb[23:16];
                    2'd1:    w_data_nxt = w_rgb[15:8];
                    default: w_data_nxt = w_rgb[7:0];
                endcase
                // Next pixel is fetched during the G byte of the current one
                if (r_ph == 2'd1 && r_cnt <= c_RD_LAST) begin
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = r_paddr;
                    w_paddr_nxt = w_paddr_inc;
                end
                if (r_cnt == c_PIX_LAST) begin
                    w_state_nxt = S_GAP;
                    w_gcnt_nxt  = '0;
                end
            end
            default: begin
                w_done_nxt = (r_gcnt == '0);
                w_gcnt_nxt = r_gcnt + c_GW'(1);
                if (r_gcnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ph        <= 2'd0;
            r_gcnt      <= '0;
            r_sa        <= 17'd0;
            r_paddr     <= 17'd0;
            r_hold      <= 24'd0;
            r_rd_q      <= 1'b0;
            r_vram_rd   <= 1'b0;
            r_vram_addr <= 17'd0;
            r_data      <= 8'd0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ph        <= w_ph_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_sa        <= w_sa_nxt;
            r_paddr     <= w_paddr_nxt;
            r_hold      <= w_rgb;
            r_rd_q      <= r_vram_rd;
            r_vram_rd   <= w_rd_nxt;
            r_vram_addr <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_en        <= w_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.vram_rd   = r_vram_rd;
    assign bus.vram_addr = r_vram_addr;
    assign bus.data8b    = r_data;
    assign bus.en        = r_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_pix24to8_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix24to8_tx
// Description : Directed self-checking bench for pix24to8_tx (NPIX=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix24to8_tx;
    localparam int c_NPIX  = 2;
    localparam int c_DEPTH = 76800;
    localparam int c_GAP   = 4;
    localparam int c_NB    = 3*c_NPIX + 7;

    logic        dclk = 1'b0;
    logic        rst  = 1'b1;
    logic [23:0] r_rgb;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  e [c_NB];

    pix24to8_tx_if bus ();

    pix24to8_tx #(
        .NPIX       (c_NPIX),
        .VRAM_DEPTH (c_DEPTH),
        .GAP        (c_GAP)
    ) dut (
        .dclk (dclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 dclk = ~dclk;

    function automatic logic [23:0] vram(input logic [16:0] a);
        case (a)
            17'h00000: return 24'hD4E5F6;
            17'h00001: return 24'h0A0B0C;
            17'h00010: return 24'h112233;
            17'h00011: return 24'h445566;
            17'h00012: return 24'h778899;
            17'h12BFF: return 24'hA1B2C3;
            default:   return 24'hEEEEEE;
        endcase
    endfunction

    // Read data is only meaningful the cycle after a strobe; junk otherwise
    always @(posedge dclk) r_rgb <= bus.vram_rd ? vram(bus.vram_addr) : 24'h5A5A5A;
    assign bus.vram_r = r_rgb[23:16];
    assign bus.vram_g = r_rgb[15:8];
    assign bus.vram_b = r_rgb[7:0];

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_packet(input logic [16:0] sa, input logic [16:0] a0, input logic [16:0] a1);
        bus.start     = 1'b1;
        bus.startaddr = sa;
        tick();
        bus.start     = 1'b0;
        bus.startaddr = 17'h1AAAA;
        chk("setup_busy", 32'(bus.busy), 32'd1);
        chk("setup_en", 32'(bus.en), 32'd0);
        for (int j = 0; j < c_NB; j++) begin
            if (j == 3) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk($sformatf("en[%0d]", j), 32'(bus.en), 32'd1);
            chk($sformatf("byte[%0d]", j), 32'(bus.data8b), 32'(e[j]));
            chk($sformatf("rd[%0d]", j), 32'(bus.vram_rd), 32'(j == 5 || j == 8));
            if (j == 5) chk("addr_pix0", 32'(bus.vram_addr), 32'(a0));
            if (j == 8) chk("addr_pix1", 32'(bus.vram_addr), 32'(a1));
            chk($sformatf("done[%0d]", j), 32'(bus.done), 32'd0);
        end
        tick();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("gap0_en", 32'(bus.en), 32'd0);
        chk("gap0_data", 32'(bus.data8b), 32'd0);
        chk("gap0_busy", 32'(bus.busy), 32'd1);
        for (int g = 1; g < c_GAP; g++) begin
            tick();
            chk($sformatf("gap%0d_en", g), 32'(bus.en), 32'd0);
            chk($sformatf("gap%0d_busy", g), 32'(bus.busy), 32'd1);
            chk($sformatf("gap%0d_done", g), 32'(bus.done), 32'd0);
        end
        // Start during the final gap cycle must be dropped
        bus.start     = 1'b1;
        bus.startaddr = 17'h00010;
        tick();
        bus.start = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("idle_busy2", 32'(bus.busy), 32'd0);
        chk("idle_en", 32'(bus.en), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.startaddr = 17'd0;
        rst           = 1'b1;
        tick();
        tick();
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_data", 32'(bus.data8b), 32'd0);
        chk("rst_rd", 32'(bus.vram_rd), 32'd0);
        chk("rst_addr", 32'(bus.vram_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        e = '{8'h00, 8'h00, 8'h10, 8'h04, 8'h40, 8'h00, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_packet(17'h00010, 17'h00010, 17'h00011);

        e = '{8'h01, 8'h2B, 8'hFF, 8'h04, 8'h40, 8'h00, 8'h00,
              8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        run_packet(17'h12BFF, 17'h12BFF, 17'h00000);

        e = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h40, 8'h00, 8'h00,
              8'hD4, 8'hE5, 8'hF6, 8'h0A, 8'h0B, 8'h0C};
        run_packet(17'h1FFFF, 17'h00000, 17'h00001);

        // Reset during pixel-0 G byte, with start asserted alongside it
        bus.start     = 1'b1;
        bus.startaddr = 17'h00010;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_G", 32'(bus.data8b), 32'h22);
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("midrst_en", 32'(bus.en), 32'd0);
        chk("midrst_data", 32'(bus.data8b), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rd", 32'(bus.vram_rd), 32'd0);
        rst = 1'b0;

        e = '{8'h00, 8'h00, 8'h11, 8'h04, 8'h40, 8'h00, 8'h00,
              8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        run_packet(17'h00011, 17'h00011, 17'h00012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
